// File: rtl/f_le_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share a single double-precision
// less-or-equal comparator through a two-stage (S1 operand / S2 result) pipeline.

package f_le_pkg;
    localparam int FLEN = 64;
endpackage

// Double-precision a <= b; err flags any NaN operand (quiet or signalling).
module f_le_cmp
    import f_le_pkg::*;
(
    input  logic [FLEN-1:0] a,
    input  logic [FLEN-1:0] b,
    output logic            res,
    output logic            err
);
    localparam int EXP_W = 11;
    localparam int MAN_W = 52;

    logic a_nan, b_nan, both_zero, mag_le, mag_ge;

    always_comb begin
        a_nan     = (&a[FLEN-2 -: EXP_W]) && (|a[MAN_W-1:0]);
        b_nan     = (&b[FLEN-2 -: EXP_W]) && (|b[MAN_W-1:0]);
        both_zero = ~|{a[FLEN-2:0], b[FLEN-2:0]};
        mag_le    = a[FLEN-2:0] <= b[FLEN-2:0];
        mag_ge    = a[FLEN-2:0] >= b[FLEN-2:0];
        err       = a_nan || b_nan;
        if (err) begin
            res = 1'b0;
        end else if (both_zero) begin
            res = 1'b1;
        end else if (a[FLEN-1] != b[FLEN-1]) begin
            res = a[FLEN-1];
        end else if (a[FLEN-1]) begin
            // Both negative: larger magnitude is the smaller value.
            res = mag_ge;
        end else begin
            res = mag_le;
        end
    end
endmodule

// Handshake rule for both sides: a transfer happens on a rising edge where
// valid and ready are both high; the source holds its payload until then.
module f_le_arbiter
    import f_le_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ-1:0][FLEN-1:0]  req_a,
    input  logic [N_REQ-1:0][FLEN-1:0]  req_b,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [$clog2(N_REQ)-1:0]    rsp_id,
    output logic                        rsp_res,
    output logic                        rsp_err
);
    localparam int IDW = $clog2(N_REQ);

    logic            s1_valid_q, s1_valid_d;
    logic [FLEN-1:0] s1_a_q, s1_a_d;
    logic [FLEN-1:0] s1_b_q, s1_b_d;
    logic [IDW-1:0]  s1_id_q, s1_id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_res_q, rsp_res_d;
    logic            rsp_err_q, rsp_err_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

    logic            cmp_res, cmp_err;
    logic            s2_load, accept_en, accept;
    logic            gnt_found;
    logic [IDW-1:0]  gnt_idx;

    f_le_cmp u_cmp (
        .a   (s1_a_q),
        .b   (s1_b_q),
        .res (cmp_res),
        .err (cmp_err)
    );

    assign s2_load   = s1_valid_q && (!rsp_valid_q || rsp_ready);
    assign accept_en = !s1_valid_q || s2_load;

    // Search upward from rr_ptr_q, wrapping at N_REQ (which need not be a power of two).
    always_comb begin
        int             cand;
        logic [IDW-1:0] cand_idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IDW'(cand);
            if (!gnt_found && req_valid[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    assign accept = !rst && accept_en && gnt_found;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = accept && (gnt_idx == IDW'(i));
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_id_d     = s1_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_res_d   = rsp_res_q;
        rsp_err_d   = rsp_err_q;
        rsp_id_d    = rsp_id_q;
        rr_ptr_d    = rr_ptr_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = req_a[gnt_idx];
            s1_b_d     = req_b[gnt_idx];
            s1_id_d    = gnt_idx;
            rr_ptr_d   = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            rsp_valid_d = 1'b1;
            rsp_res_d   = cmp_res;
            rsp_err_d   = cmp_err;
            rsp_id_d    = s1_id_q;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_res_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_id_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_id_q     <= s1_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
            rsp_err_q   <= rsp_err_d;
            rsp_id_q    <= rsp_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_id    = rsp_id_q;

    always @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(req_ready));
        end
    end
endmodule

// File: tb/tb_f_le_arbiter.sv
// Bench for f_le_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model (grant order, occupancy, response queue).

module tb_f_le_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int W   = IDW + 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N-1:0]         req_valid = '0;
    logic [N-1:0]         req_ready;
    logic [N-1:0][63:0]   req_a = '0;
    logic [N-1:0][63:0]   req_b = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b1;
    logic [IDW-1:0]       rsp_id;
    logic                 rsp_res;
    logic                 rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    f_le_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_res   (rsp_res),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [W-1:0] exp_q[$];   // {id, res, err} in acceptance order
    int           cyc_q[$];   // edge count at which each entry was accepted
    int           cyc = 0;
    int           m_ptr = 0;
    logic [N-1:0] m_acc_mask = '0;

    function automatic logic [1:0] ref_le(input logic [63:0] a, input logic [63:0] b);
        logic na, nb;
        na = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
        nb = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
        if (na || nb) return 2'b01;
        return {($bitstoreal(a) <= $bitstoreal(b)), 1'b0};
    endfunction

    function automatic int m_grant();
        int c;
        for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    // Two entries in flight means both stages are full: room only if the output drains.
    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = m_grant();
        if (!rst && g >= 0 && (exp_q.size() < 2 || rsp_ready)) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic m_rsp_valid();
        return (exp_q.size() > 0) && (cyc_q[0] < cyc);
    endfunction

    always @(posedge clk) begin
        logic [N-1:0] acc;
        logic         pop;
        int           g;
        acc = m_ready();
        pop = m_rsp_valid() && rsp_ready;
        g   = m_grant();
        cyc++;
        if (rst) begin
            exp_q.delete();
            cyc_q.delete();
            m_ptr      = 0;
            m_acc_mask = '0;
        end else begin
            if (pop) begin
                void'(exp_q.pop_front());
                void'(cyc_q.pop_front());
            end
            if (|acc) begin
                exp_q.push_back({IDW'(g), ref_le(req_a[g], req_b[g])});
                cyc_q.push_back(cyc);
                m_ptr = (g + 1) % N;
            end
            m_acc_mask = acc;
        end
    end

    function automatic logic [63:0] rand_fp();
        case ($urandom_range(0, 12))
            0:       return 64'h0000000000000000;
            1:       return 64'h8000000000000000;
            2:       return 64'h3FF0000000000000;
            3:       return 64'h4000000000000000;
            4:       return 64'hBFF0000000000000;
            5:       return 64'h7FF0000000000000;
            6:       return 64'hFFF0000000000000;
            7:       return 64'h7FF8000000000000;
            8:       return 64'h7FF0000000000001;
            9:       return 64'h0000000000000001;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '1; rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ready actual=%b expected=0000", req_ready);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_res, rsp_err} !== 5'b0) begin
            n_fail++; $display("FAIL reset_rsp actual=%b%b%b%b expected=0000", rsp_valid, rsp_id, rsp_res, rsp_err);
        end
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ready_held actual=%b expected=0000", req_ready);
        end
        @(negedge clk);
        rst = 1'b0; req_valid = '0;
    endtask

    task automatic test_directed();
        logic [63:0] av[3] = '{64'h3FF0000000000000, 64'h7FF8000000000000, 64'h8000000000000000};
        logic [63:0] bv[3] = '{64'h4000000000000000, 64'h3FF0000000000000, 64'h0000000000000000};
        int          ids[3] = '{0, 1, 1};
        logic [1:0]  re[3]  = '{2'b10, 2'b01, 2'b10};
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            req_valid = '0; req_valid[ids[t]] = 1'b1;
            req_a[ids[t]] = av[t]; req_b[ids[t]] = bv[t]; rsp_ready = 1'b1;
            #1;
            n_checks++;
            if (req_ready !== (4'b0001 << ids[t])) begin
                n_fail++; $display("FAIL dir_grant t=%0d actual=%b expected=%b", t, req_ready, 4'b0001 << ids[t]);
            end
            @(negedge clk);
            req_valid = '0;
            #1;
            n_checks++;
            if (rsp_valid !== 1'b0) begin
                n_fail++; $display("FAIL dir_early t=%0d actual=%b expected=0", t, rsp_valid);
            end
            @(negedge clk);
            #1;
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_res, rsp_err} !== {1'b1, IDW'(ids[t]), re[t]}) begin
                n_fail++; $display("FAIL dir_rsp t=%0d actual=%b/%0d/%b/%b expected=1/%0d/%b/%b",
                                   t, rsp_valid, rsp_id, rsp_res, rsp_err, ids[t], re[t][1], re[t][0]);
            end
        end
    endtask

    task automatic test_round_robin();
        @(negedge clk); rst = 1'b1; req_valid = '0;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_a[i] = rand_fp(); req_b[i] = rand_fp();
        end
        req_valid = '1; rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            n_checks++;
            if (req_ready !== (4'b0001 << (c % N))) begin
                n_fail++; $display("FAIL rr_grant c=%0d actual=%b expected=%b", c, req_ready, 4'b0001 << (c % N));
            end
            if (c >= 2) begin
                n_checks++;
                if (!rsp_valid || rsp_id !== IDW'((c - 2) % N)) begin
                    n_fail++; $display("FAIL rr_rsp_id c=%0d actual=%b/%0d expected=1/%0d", c, rsp_valid, rsp_id, (c - 2) % N);
                end
                n_checks++;
                if ({rsp_id, rsp_res, rsp_err} !== exp_q[0]) begin
                    n_fail++; $display("FAIL rr_rsp_val c=%0d actual=%h expected=%h", c, {rsp_id, rsp_res, rsp_err}, exp_q[0]);
                end
            end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        int accepts, pops;
        logic [W:0] snap;
        logic       have_snap;
        accepts = 0; pops = 0; have_snap = 1'b0; snap = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); req_valid = '0; rsp_ready = 1'b1;
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_valid = '1; rsp_ready = 1'b0;
            #1;
            accepts += $countones(req_ready & req_valid);
            n_checks++;
            if (req_ready !== m_ready()) begin
                n_fail++; $display("FAIL bp_ready c=%0d actual=%b expected=%b", c, req_ready, m_ready());
            end
            if (rsp_valid) begin
                if (!have_snap) begin
                    snap = {rsp_valid, rsp_id, rsp_res, rsp_err}; have_snap = 1'b1;
                end else begin
                    n_checks++;
                    if ({rsp_valid, rsp_id, rsp_res, rsp_err} !== snap) begin
                        n_fail++; $display("FAIL bp_stable c=%0d actual=%h expected=%h", c, {rsp_valid, rsp_id, rsp_res, rsp_err}, snap);
                    end
                end
            end
        end
        n_checks++;
        if (accepts !== 2) begin
            n_fail++; $display("FAIL bp_accepts actual=%0d expected=2", accepts);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req_valid = '0; rsp_ready = 1'b1;
            #1;
            n_checks++;
            if (rsp_valid !== m_rsp_valid()) begin
                n_fail++; $display("FAIL bp_drain_valid c=%0d actual=%b expected=%b", c, rsp_valid, m_rsp_valid());
            end
            if (m_rsp_valid()) begin
                pops++;
                n_checks++;
                if ({rsp_id, rsp_res, rsp_err} !== exp_q[0]) begin
                    n_fail++; $display("FAIL bp_drain_rsp c=%0d actual=%h expected=%h", c, {rsp_id, rsp_res, rsp_err}, exp_q[0]);
                end
            end
        end
        n_checks++;
        if (pops !== 2) begin
            n_fail++; $display("FAIL bp_pops actual=%0d expected=2", pops);
        end
    endtask

    task automatic test_reset_midflight();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); req_valid = '1; rsp_ready = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL mid_rst_ready actual=%b expected=0000", req_ready);
        end
        @(negedge clk);
        rst = 1'b0; rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_rsp_valid actual=%b expected=0", rsp_valid);
        end
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL mid_first_grant actual=%b expected=0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || m_acc_mask[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_a[i]     = rand_fp();
                    req_b[i]     = ($urandom_range(0, 5) == 0) ? req_a[i] : rand_fp();
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            n_checks++;
            if (req_ready !== m_ready()) begin
                n_fail++; $display("FAIL rnd_ready c=%0d actual=%b expected=%b", c, req_ready, m_ready());
            end
            n_checks++;
            if (rsp_valid !== m_rsp_valid()) begin
                n_fail++; $display("FAIL rnd_rsp_valid c=%0d actual=%b expected=%b", c, rsp_valid, m_rsp_valid());
            end
            if (m_rsp_valid()) begin
                n_checks++;
                if ({rsp_id, rsp_res, rsp_err} !== exp_q[0]) begin
                    n_fail++; $display("FAIL rnd_rsp c=%0d actual=%h expected=%h", c, {rsp_id, rsp_res, rsp_err}, exp_q[0]);
                end
            end
        end
        @(negedge clk);
        req_valid = '0; rsp_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rnd_final_drain actual=%b expected=0", rsp_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_round_robin();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
